assoc_resp_checker: RTL and testbench



---
 rtl/assoc_chk_pkg.sv | 34 +++
 rtl/assoc_golden.sv | 22 ++
 rtl/assoc_resp_checker.sv | 159 +++++++++++++++
 tb/tb_assoc_resp_checker.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : assoc_chk_pkg
// Description : Shared types, constants and coverage helper for the
//               OR-associativity response checker.
// Revision    : 1.0 - initial release
// ============================================================================
package assoc_chk_pkg;

    localparam int N_IN_DEFAULT    = 3;
    localparam int NUM_VEC_DEFAULT = 2 ** N_IN_DEFAULT;
    localparam int MAX_VEC         = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Only the low num_vec bits of the (zero-extended) map are significant.
    function automatic logic all_covered(input logic [MAX_VEC-1:0] map,
                                         input int unsigned        num_vec);
        logic w_all;
        w_all = 1'b1;
        for (int unsigned i = 0; i < MAX_VEC; i++) begin
            if ((i < num_vec) && !map[i]) begin
                w_all = 1'b0;
            end
        end
        return w_all;
    endfunction

endpackage
`default_nettype wire

// File: rtl/assoc_golden.sv
`default_nettype none
// ============================================================================
// Module      : assoc_golden
// Description : Golden OR-reduction of the applied vector and a mismatch flag
//               for the two law-side outputs under test.
// Revision    : 1.0 - initial release
// ============================================================================
module assoc_golden #(
    parameter int N_IN = 3
) (
    input  logic [N_IN-1:0] i_vec,
    input  logic            i_s0,
    input  logic            i_s1,
    output logic            o_golden,
    output logic            o_mismatch
);

    assign o_golden   = |i_vec;
    assign o_mismatch = (i_s0 != o_golden) || (i_s1 != o_golden);

endmodule
`default_nettype wire

// File: rtl/assoc_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : assoc_resp_checker
// Description : Samples two OR-associativity outputs, checks them against the
//               golden OR, tracks input coverage and reports pass/fail.
// Revision    : 1.0 - initial release
// ============================================================================
module assoc_resp_checker
    import assoc_chk_pkg::*;
#(
    parameter  int N_IN        = N_IN_DEFAULT,
    parameter  int MAX_SAMPLES = 32,
    parameter  int CNT_W       = 8,
    localparam int NUM_VEC     = 2 ** N_IN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               vec_valid,
    input  logic [N_IN-1:0]    vec_in,
    input  logic               s0,
    input  logic               s1,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               cov_miss,
    output logic [CNT_W-1:0]   vec_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [NUM_VEC-1:0] cov_map,
    output logic [N_IN-1:0]    first_err_vec,
    output logic               first_err_valid
);

    localparam logic [CNT_W-1:0] C_MAX_SAMPLES = CNT_W'(MAX_SAMPLES);

    state_t             r_state,     w_state_next;
    logic               r_busy,      w_busy_next;
    logic               r_done,      w_done_next;
    logic               r_pass,      w_pass_next;
    logic               r_cov_miss,  w_cov_miss_next;
    logic [CNT_W-1:0]   r_vec_count, w_vec_count_next;
    logic [CNT_W-1:0]   r_err_count, w_err_count_next;
    logic [NUM_VEC-1:0] r_cov_map,   w_cov_map_next;
    logic [N_IN-1:0]    r_ferr_vec,  w_ferr_vec_next;
    logic               r_ferr_vld,  w_ferr_vld_next;
    logic               w_golden;
    logic               w_mismatch;

    assoc_golden #(
        .N_IN (N_IN)
    ) u_golden (
        .i_vec      (vec_in),
        .i_s0       (s0),
        .i_s1       (s1),
        .o_golden   (w_golden),
        .o_mismatch (w_mismatch)
    );

    always_comb begin
        w_state_next     = r_state;
        w_busy_next      = r_busy;
        w_done_next      = r_done;
        w_pass_next      = r_pass;
        w_cov_miss_next  = r_cov_miss;
        w_vec_count_next = r_vec_count;
        w_err_count_next = r_err_count;
        w_cov_map_next   = r_cov_map;
        w_ferr_vec_next  = r_ferr_vec;
        w_ferr_vld_next  = r_ferr_vld;

        case (r_state)
            RUN: begin
                if (vec_valid) begin
                    // Counters saturate rather than wrap.
                    if (r_vec_count != '1) begin
                        w_vec_count_next = r_vec_count + 1'b1;
                    end
                    w_cov_map_next[vec_in] = 1'b1;
                    if (w_mismatch) begin
                        if (r_err_count != '1) begin
                            w_err_count_next = r_err_count + 1'b1;
                        end
                        if (!r_ferr_vld) begin
                            w_ferr_vec_next = vec_in;
                            w_ferr_vld_next = 1'b1;
                        end
                    end
                    // Completion looks at the post-update values so the
                    // covering sample closes the run on this same edge.
                    if (all_covered(MAX_VEC'(w_cov_map_next), NUM_VEC)) begin
                        w_state_next    = DONE;
                        w_busy_next     = 1'b0;
                        w_done_next     = 1'b1;
                        w_pass_next     = (w_err_count_next == '0);
                        w_cov_miss_next = 1'b0;
                    end else if (w_vec_count_next == C_MAX_SAMPLES) begin
                        w_state_next    = DONE;
                        w_busy_next     = 1'b0;
                        w_done_next     = 1'b1;
                        w_pass_next     = 1'b0;
                        w_cov_miss_next = 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    w_state_next     = RUN;
                    w_busy_next      = 1'b1;
                    w_done_next      = 1'b0;
                    w_pass_next      = 1'b0;
                    w_cov_miss_next  = 1'b0;
                    w_vec_count_next = '0;
                    w_err_count_next = '0;
                    w_cov_map_next   = '0;
                    w_ferr_vec_next  = '0;
                    w_ferr_vld_next  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_cov_miss  <= 1'b0;
            r_vec_count <= '0;
            r_err_count <= '0;
            r_cov_map   <= '0;
            r_ferr_vec  <= '0;
            r_ferr_vld  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_pass      <= w_pass_next;
            r_cov_miss  <= w_cov_miss_next;
            r_vec_count <= w_vec_count_next;
            r_err_count <= w_err_count_next;
            r_cov_map   <= w_cov_map_next;
            r_ferr_vec  <= w_ferr_vec_next;
            r_ferr_vld  <= w_ferr_vld_next;
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign cov_miss        = r_cov_miss;
    assign vec_count       = r_vec_count;
    assign err_count       = r_err_count;
    assign cov_map         = r_cov_map;
    assign first_err_vec   = r_ferr_vec;
    assign first_err_valid = r_ferr_vld;

endmodule
`default_nettype wire

// File: tb/tb_assoc_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_assoc_resp_checker
// Description : Self-checking bench for assoc_resp_checker with directed
//               scenarios and randomized runs against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_assoc_resp_checker;

    localparam int N_IN        = 3;
    localparam int NUM_VEC     = 8;
    localparam int MAX_SAMPLES = 32;
    localparam int CNT_W       = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               vec_valid = 1'b0;
    logic [N_IN-1:0]    vec_in = '0;
    logic               s0 = 1'b0;
    logic               s1 = 1'b0;
    logic               busy, done, pass, cov_miss, first_err_valid;
    logic [CNT_W-1:0]   vec_count, err_count;
    logic [NUM_VEC-1:0] cov_map;
    logic [N_IN-1:0]    first_err_vec;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit               m_run, m_done, m_pass, m_miss, m_fv;
    int               m_vc, m_ec, m_first;
    bit [NUM_VEC-1:0] m_seen;

    assoc_resp_checker #(
        .N_IN        (N_IN),
        .MAX_SAMPLES (MAX_SAMPLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .vec_valid       (vec_valid),
        .vec_in          (vec_in),
        .s0              (s0),
        .s1              (s1),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .cov_miss        (cov_miss),
        .vec_count       (vec_count),
        .err_count       (err_count),
        .cov_map         (cov_map),
        .first_err_vec   (first_err_vec),
        .first_err_valid (first_err_valid)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 0; m_done = 0; m_pass = 0; m_miss = 0; m_fv = 0;
        m_vc = 0; m_ec = 0; m_first = 0; m_seen = '0;
    endtask

    task automatic model_update(input bit st, input bit v, input int vec, input bit a, input bit b);
        bit g;
        int distinct;
        if (!m_run) begin
            if (st) begin
                model_reset();
                m_run = 1;
            end
        end else if (v) begin
            g = (vec != 0);
            m_vc = (m_vc < 255) ? m_vc + 1 : 255;
            m_seen[vec] = 1'b1;
            if (a != g || b != g) begin
                if (m_ec < 255) m_ec = m_ec + 1;
                if (!m_fv) begin m_fv = 1; m_first = vec; end
            end
            distinct = 0;
            for (int i = 0; i < NUM_VEC; i++) distinct += m_seen[i];
            if (distinct == NUM_VEC) begin
                m_run = 0; m_done = 1; m_pass = (m_ec == 0); m_miss = 0;
            end else if (m_vc == MAX_SAMPLES) begin
                m_run = 0; m_done = 1; m_pass = 0; m_miss = 1;
            end
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rise.
    task automatic step(input bit st, input bit v, input int vec, input bit a, input bit b);
        @(negedge clk);
        start = st; vec_valid = v; vec_in = N_IN'(vec); s0 = a; s1 = b;
        @(posedge clk);
        #1;
        model_update(st, v, vec, a, b);
        start = 1'b0; vec_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, pass, cov_miss, vec_count, err_count, cov_map, first_err_vec, first_err_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b vc=%0d ec=%0d cov=%h expected all zero",
                     busy, done, vec_count, err_count, cov_map);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_full_pass();
        step(1, 0, 0, 0, 0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
        for (int v = 0; v < 8; v++) begin
            step(0, 1, v, v != 0, v != 0);
            if (v == 6) begin
                checks++;
                if (done !== 1'b0) begin errors++; $display("FAIL early_done: got %b expected 0", done); end
            end
        end
        checks++;
        if ({done, pass, busy, first_err_valid} !== 4'b1100) begin
            errors++; $display("FAIL full_flags: got done/pass/busy/fev=%b expected 1100", {done, pass, busy, first_err_valid});
        end
        checks++;
        if (vec_count !== 8'd8 || err_count !== 8'd0 || cov_map !== 8'hFF) begin
            errors++; $display("FAIL full_counts: got vc=%0d ec=%0d cov=%h expected 8 0 ff", vec_count, err_count, cov_map);
        end
    endtask

    task automatic test_single_error();
        step(1, 0, 0, 0, 0);
        for (int v = 0; v < 8; v++) step(0, 1, v, v != 0, (v == 4) ? 1'b0 : (v != 0));
        checks++;
        if ({done, pass} !== 2'b10 || err_count !== 8'd1) begin
            errors++; $display("FAIL single_err: got done=%b pass=%b ec=%0d expected 1 0 1", done, pass, err_count);
        end
        checks++;
        if (first_err_vec !== 3'b100 || first_err_valid !== 1'b1) begin
            errors++; $display("FAIL first_err: got vec=%b valid=%b expected 100 1", first_err_vec, first_err_valid);
        end
    endtask

    task automatic test_cov_miss();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            step(0, 1, i % 7, (i % 7) != 0, (i % 7) != 0);
            if (i == 30) begin
                checks++;
                if (done !== 1'b0 || vec_count !== 8'd31) begin
                    errors++; $display("FAIL miss_early: got done=%b vc=%0d expected 0 31", done, vec_count);
                end
            end
        end
        checks++;
        if ({done, cov_miss, pass} !== 3'b110 || cov_map !== 8'h7F || vec_count !== 8'd32) begin
            errors++; $display("FAIL cov_miss: got done=%b miss=%b pass=%b cov=%h vc=%0d expected 1 1 0 7f 32",
                               done, cov_miss, pass, cov_map, vec_count);
        end
    endtask

    task automatic test_gaps_dup_start();
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 5, 1, 1);
        step(0, 1, 0, 0, 0);
        checks++;
        if (vec_count !== 8'd2 || cov_map !== 8'h01) begin
            errors++; $display("FAIL dup_vec: got vc=%0d cov=%h expected 2 01", vec_count, cov_map);
        end
        step(0, 1, 1, 1, 1);
        step(0, 0, 7, 1, 1);
        step(0, 1, 2, 1, 1);
        step(1, 1, 3, 1, 1);
        step(1, 0, 0, 0, 0);
        checks++;
        if (busy !== 1'b1 || vec_count !== 8'd5) begin
            errors++; $display("FAIL start_in_run: got busy=%b vc=%0d expected 1 5", busy, vec_count);
        end
        for (int v = 4; v < 8; v++) step(0, 1, v, 1, 1);
        checks++;
        if (vec_count !== 8'd9 || cov_map !== 8'hFF || {done, pass} !== 2'b11) begin
            errors++; $display("FAIL gaps_result: got vc=%0d cov=%h done=%b pass=%b expected 9 ff 1 1",
                               vec_count, cov_map, done, pass);
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 0, 0);
        for (int v = 0; v < 4; v++) step(0, 1, v, v != 0, v != 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, cov_miss, vec_count, err_count, cov_map, first_err_vec, first_err_valid} !== '0) begin
            errors++; $display("FAIL async_reset: got busy=%b vc=%0d cov=%h expected all zero", busy, vec_count, cov_map);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 0, 0, 0, 0);
        for (int v = 0; v < 8; v++) step(0, 1, v, v != 0, v != 0);
        checks++;
        if (pass !== 1'b1 || vec_count !== 8'd8) begin
            errors++; $display("FAIL post_reset_run: got pass=%b vc=%0d expected 1 8", pass, vec_count);
        end
    endtask

    task automatic test_restart();
        step(0, 1, 3, 0, 0);
        checks++;
        if (done !== 1'b1 || vec_count !== 8'd8) begin
            errors++; $display("FAIL done_hold: got done=%b vc=%0d expected 1 8", done, vec_count);
        end
        step(1, 0, 0, 0, 0);
        step(0, 1, 5, 0, 1);
        checks++;
        if ({done, busy} !== 2'b01 || err_count !== 8'd1 || first_err_vec !== 3'b101) begin
            errors++; $display("FAIL restart: got done=%b busy=%b ec=%0d fev=%b expected 0 1 1 101",
                               done, busy, err_count, first_err_vec);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_bus;
        bit a, b, g;
        int vec;
        // Drain any run in progress so the model and DUT start aligned.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int run = 0; run < 6; run++) begin
            step(1, 0, 0, 0, 0);
            for (int cyc = 0; cyc < 200 && !m_done; cyc++) begin
                vec = (run == 5) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 7));
                g = (vec != 0);
                a = ($urandom_range(0, 15) == 0) ? !g : g;
                b = ($urandom_range(0, 15) == 0) ? !g : g;
                step(1'($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), vec, a, b);
                exp_bus = {m_run, m_done, m_pass, m_miss, 8'(m_vc), 8'(m_ec), m_seen, 3'(m_first), m_fv};
                checks++;
                if ({busy, done, pass, cov_miss, vec_count, err_count, cov_map, first_err_vec, first_err_valid} !== exp_bus) begin
                    errors++;
                    $display("FAIL random_run%0d: got b/d/p/m=%b vc=%0d ec=%0d cov=%h fe=%b/%b expected %b %0d %0d %h %0d/%b",
                             run, {busy, done, pass, cov_miss}, vec_count, err_count, cov_map, first_err_vec,
                             first_err_valid, {m_run, m_done, m_pass, m_miss}, m_vc, m_ec, m_seen, m_first, m_fv);
                end
            end
            checks++;
            if (done !== 1'b1) begin
                errors++; $display("FAIL random_timeout%0d: got done=%b expected 1", run, done);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_pass();
        test_single_error();
        test_cov_miss();
        test_gaps_dup_start();
        test_async_reset();
        test_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
